// File: rtl/i281_exec_ctrl.sv
// i281 execution controller: turns front-panel run/step/halt buttons into the
// core's run (clock-enable), stops on a PC breakpoint or an instruction limit,
// and counts executed instructions.
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   btn_run/step/halt  asynchronous buttons (synchronized and edge-detected here)
//   clr_cnt            synchronous clear of cycle_count
//   bp_enable, bp_addr PC breakpoint
//   current_pc         PC of the instruction about to execute
//   cycle_limit        max instructions per run, 0 = unlimited
//   run                CPU clock-enable (combinational from registers)
//   state              0=IDLE 1=RUN 2=STEP 3=HALT
//   cycle_count        saturating count of run=1 cycles
//   halted_at_bp       sticky: stopped on breakpoint
//   limit_hit          sticky: stopped on cycle_limit
module i281_exec_ctrl #(
    parameter int unsigned PC_W  = 6,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic             btn_halt,
    input  logic             clr_cnt,
    input  logic             bp_enable,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  current_pc,
    input  logic [CNT_W-1:0] cycle_limit,
    output logic             run,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_count,
    output logic             halted_at_bp,
    output logic             limit_hit
);

    localparam int unsigned NBTN = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              hab_d, lh_d;
    logic              bp_skip, skip_d;

    logic [NBTN-1:0]   btn_raw, btn_s1, btn_s2, btn_s2_d, btn_p;
    logic              run_p, step_p, halt_p;
    logic              bp_match, lim_match;

    // Button synchronizers and rising-edge detect, bit order {halt, step, run}
    assign btn_raw = {btn_halt, btn_step, btn_run};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            btn_s2_d <= '0;
        end else begin
            btn_s1   <= btn_raw;
            btn_s2   <= btn_s1;
            btn_s2_d <= btn_s2;
        end
    end

    assign btn_p  = btn_s2 & ~btn_s2_d;
    assign run_p  = btn_p[0];
    assign step_p = btn_p[1];
    assign halt_p = btn_p[2];

    // Stop conditions; bp_skip masks the breakpoint for the resumed instruction
    assign bp_match  = bp_enable && (current_pc == bp_addr) && !bp_skip;
    assign lim_match = (cycle_limit != '0) && (cycle_count == cycle_limit);

    assign run   = ((state_q == ST_RUN) && !bp_match && !lim_match) || (state_q == ST_STEP);
    assign state = state_q;

    // State and status registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cycle_count  <= '0;
            halted_at_bp <= 1'b0;
            limit_hit    <= 1'b0;
            bp_skip      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cycle_count  <= cnt_d;
            halted_at_bp <= hab_d;
            limit_hit    <= lh_d;
            bp_skip      <= skip_d;
        end
    end

    // Next-state, counter and flag logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cycle_count;
        hab_d   = halted_at_bp;
        lh_d    = limit_hit;
        skip_d  = bp_skip;

        if (run) begin
            skip_d = 1'b0;
            if (cycle_count != CNT_MAX) begin
                cnt_d = cycle_count + CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (step_p) begin
                    state_d = ST_STEP;
                end else if (run_p) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_p) begin
                    state_d = ST_IDLE;
                end else if (bp_match) begin
                    state_d = ST_HALT;
                    hab_d   = 1'b1;
                end else if (lim_match) begin
                    state_d = ST_HALT;
                    lh_d    = 1'b1;
                end
            end
            ST_STEP: begin
                state_d = ST_IDLE;
            end
            ST_HALT: begin
                if (halt_p) begin
                    state_d = ST_IDLE;
                    hab_d   = 1'b0;
                    lh_d    = 1'b0;
                end else if (step_p) begin
                    state_d = ST_STEP;
                    hab_d   = 1'b0;
                    lh_d    = 1'b0;
                end else if (run_p) begin
                    state_d = ST_RUN;
                    hab_d   = 1'b0;
                    lh_d    = 1'b0;
                    // Resuming after a limit stop starts a fresh budget
                    if (limit_hit) begin
                        cnt_d = '0;
                    end
                    // Resuming from a breakpoint must execute the instruction at bp_addr
                    if (halted_at_bp) begin
                        skip_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_IDLE) begin
            skip_d = 1'b0;
        end

        if (clr_cnt) begin
            cnt_d = '0;
        end
    end

endmodule

// File: tb/tb_i281_exec_ctrl.sv
// Self-checking bench for i281_exec_ctrl: a reset/button-latency vector table,
// hand sequences for breakpoint, limit, step, simultaneous buttons, async reset,
// clear and saturation, then randomized button traffic against a cycle model.
module tb_i281_exec_ctrl;

    localparam int unsigned PC_W  = 6;
    localparam int unsigned CNT_W = 16;
    localparam int S_IDLE = 0, S_RUN = 1, S_STEP = 2, S_HALT = 3;
    localparam int CMAX   = 65535;
    localparam int PC_MOD = 64;

    logic             clock, reset;
    logic             btn_run, btn_step, btn_halt, clr_cnt, bp_enable;
    logic [PC_W-1:0]  bp_addr, current_pc;
    logic [CNT_W-1:0] cycle_limit;
    logic             run, halted_at_bp, limit_hit;
    logic [1:0]       state;
    logic [CNT_W-1:0] cycle_count;

    logic [3:0]       lim4, cnt4;
    logic             run4, hab4, lh4;
    logic [1:0]       state4;

    i281_exec_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .btn_run(btn_run), .btn_step(btn_step), .btn_halt(btn_halt),
        .clr_cnt(clr_cnt), .bp_enable(bp_enable), .bp_addr(bp_addr),
        .current_pc(current_pc), .cycle_limit(cycle_limit),
        .run(run), .state(state), .cycle_count(cycle_count),
        .halted_at_bp(halted_at_bp), .limit_hit(limit_hit)
    );

    // Narrow-counter instance sharing the stimulus, unlimited, for saturation
    i281_exec_ctrl #(.PC_W(PC_W), .CNT_W(4)) dut4 (
        .clock(clock), .reset(reset),
        .btn_run(btn_run), .btn_step(btn_step), .btn_halt(btn_halt),
        .clr_cnt(clr_cnt), .bp_enable(bp_enable), .bp_addr(bp_addr),
        .current_pc(current_pc), .cycle_limit(lim4),
        .run(run4), .state(state4), .cycle_count(cnt4),
        .halted_at_bp(hab4), .limit_hit(lh4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int nvec, nerr;
    int run_seen;

    // Behavioural model: controller mode, counters and a per-button history of
    // levels seen at the last three clock edges (index 0 = newest). A press seen
    // at edge k takes effect at edge k+2.
    int ms, m_cnt, m_pc;
    bit m_hab, m_lh, m_skip, m_r;
    bit [2:0] h_run, h_step, h_halt;
    int n_ms, n_cnt, n_pc;
    bit n_hab, n_lh, n_skip;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ms = S_IDLE; m_cnt = 0; m_hab = 0; m_lh = 0; m_skip = 0;
        h_run = '0; h_step = '0; h_halt = '0;
    endtask

    task automatic model_eval();
        bit pr, ps, ph, bpm, lim;
        pr  = h_run[1]  & ~h_run[2];
        ps  = h_step[1] & ~h_step[2];
        ph  = h_halt[1] & ~h_halt[2];
        bpm = bp_enable && (int'(current_pc) == int'(bp_addr)) && !m_skip;
        lim = (cycle_limit != 0) && (m_cnt == int'(cycle_limit));
        m_r = (ms == S_RUN && !bpm && !lim) || (ms == S_STEP);

        n_ms = ms; n_hab = m_hab; n_lh = m_lh;
        n_skip = m_r ? 1'b0 : m_skip;
        n_cnt = (m_r && m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
        n_pc  = m_r ? (m_pc + 1) % PC_MOD : m_pc;

        if (ms == S_IDLE) begin
            if (ps) n_ms = S_STEP;
            else if (pr) n_ms = S_RUN;
        end else if (ms == S_RUN) begin
            if (ph) n_ms = S_IDLE;
            else if (bpm) begin n_ms = S_HALT; n_hab = 1; end
            else if (lim) begin n_ms = S_HALT; n_lh = 1; end
        end else if (ms == S_STEP) begin
            n_ms = S_IDLE;
        end else begin
            if (ph || ps || pr) begin n_hab = 0; n_lh = 0; end
            if (ph) n_ms = S_IDLE;
            else if (ps) n_ms = S_STEP;
            else if (pr) begin
                n_ms = S_RUN;
                if (m_lh) n_cnt = 0;
                if (m_hab) n_skip = 1;
            end
        end
        if (n_ms == S_IDLE) n_skip = 0;
        if (clr_cnt) n_cnt = 0;
    endtask

    task automatic check_model();
        chk("run",          int'(run),          int'(m_r));
        chk("state",        int'(state),        ms);
        chk("cycle_count",  int'(cycle_count),  m_cnt);
        chk("halted_at_bp", int'(halted_at_bp), int'(m_hab));
        chk("limit_hit",    int'(limit_hit),    int'(m_lh));
    endtask

    // One clock: evaluate and compare mid-cycle, then commit after the edge
    task automatic cyc();
        #1;
        model_eval();
        check_model();
        if (run) run_seen++;
        h_run  = {h_run[1:0],  btn_run};
        h_step = {h_step[1:0], btn_step};
        h_halt = {h_halt[1:0], btn_halt};
        @(posedge clock);
        #1;
        ms = n_ms; m_cnt = n_cnt; m_hab = n_hab; m_lh = n_lh; m_skip = n_skip; m_pc = n_pc;
        current_pc = PC_W'(m_pc);
    endtask

    task automatic press(input bit r, input bit s, input bit h, input int hold);
        btn_run = r; btn_step = s; btn_halt = h;
        repeat (hold) cyc();
        btn_run = 0; btn_step = 0; btn_halt = 0;
    endtask

    task automatic wait_state(input int target, input int budget, input string nm);
        int n;
        n = 0;
        while (int'(state) != target && n < budget) begin
            cyc();
            n++;
        end
        chk(nm, int'(state), target);
    endtask

    task automatic do_reset();
        #2 reset = 1;
        #1 reset = 0;
        model_reset();
    endtask

    typedef struct {
        bit br, bs, bh;
        bit er;
        int es;
        int ec;
    } vec_t;

    vec_t tbl[13];

    initial begin
        nvec = 0; nerr = 0; run_seen = 0;
        reset = 1; btn_run = 0; btn_step = 0; btn_halt = 0; clr_cnt = 0;
        bp_enable = 0; bp_addr = '0; current_pc = '0; cycle_limit = '0; lim4 = '0;
        m_pc = 0;
        model_reset();

        tbl[0]  = '{1,0,0, 0, S_IDLE, 0};
        tbl[1]  = '{1,0,0, 0, S_IDLE, 0};
        tbl[2]  = '{1,0,0, 0, S_IDLE, 0};
        tbl[3]  = '{1,0,0, 1, S_RUN,  0};
        tbl[4]  = '{1,0,0, 1, S_RUN,  1};
        tbl[5]  = '{0,0,0, 1, S_RUN,  2};
        tbl[6]  = '{0,0,0, 1, S_RUN,  3};
        tbl[7]  = '{0,0,0, 1, S_RUN,  4};
        tbl[8]  = '{0,0,1, 1, S_RUN,  5};
        tbl[9]  = '{0,0,0, 1, S_RUN,  6};
        tbl[10] = '{0,0,0, 1, S_RUN,  7};
        tbl[11] = '{0,0,0, 0, S_IDLE, 8};
        tbl[12] = '{0,0,0, 0, S_IDLE, 8};

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_run",   int'(run), 0);
        chk("rst_state", int'(state), S_IDLE);
        chk("rst_count", int'(cycle_count), 0);
        chk("rst_hab",   int'(halted_at_bp), 0);
        chk("rst_lh",    int'(limit_hit), 0);
        reset = 0;
        model_reset();

        // Run button held five clocks, then halt: latency and single entry
        for (int i = 0; i < 13; i++) begin
            btn_run = tbl[i].br; btn_step = tbl[i].bs; btn_halt = tbl[i].bh;
            #1;
            chk($sformatf("tbl%0d_run", i),   int'(run),         int'(tbl[i].er));
            chk($sformatf("tbl%0d_state", i), int'(state),       tbl[i].es);
            chk($sformatf("tbl%0d_count", i), int'(cycle_count), tbl[i].ec);
            cyc();
        end
        btn_run = 0; btn_step = 0; btn_halt = 0;

        // Breakpoint at pc 9, then resume executes pc 9
        do_reset();
        bp_enable = 1; bp_addr = 6'd9; cycle_limit = '0;
        m_pc = 0; current_pc = '0;
        press(1, 0, 0, 2);
        wait_state(S_HALT, 40, "bp_halt_wait");
        chk("bp_hab",   int'(halted_at_bp), 1);
        chk("bp_count", int'(cycle_count), 9);
        chk("bp_pc",    int'(current_pc), 9);
        chk("bp_run",   int'(run), 0);
        press(1, 0, 0, 2);
        wait_state(S_RUN, 10, "bp_resume_wait");
        chk("bp_skip_run", int'(run), 1);
        cyc();
        chk("bp_skip_pc",  int'(current_pc), 10);
        chk("bp_flag_clr", int'(halted_at_bp), 0);
        press(0, 0, 1, 1);
        wait_state(S_IDLE, 10, "bp_idle_wait");

        // Instruction limit of 5, twice
        do_reset();
        bp_enable = 0; cycle_limit = 16'd5;
        run_seen = 0;
        press(1, 0, 0, 2);
        wait_state(S_HALT, 30, "lim_halt_wait");
        chk("lim_runs",  run_seen, 5);
        chk("lim_count", int'(cycle_count), 5);
        chk("lim_flag",  int'(limit_hit), 1);
        run_seen = 0;
        press(1, 0, 0, 2);
        wait_state(S_RUN, 10, "lim_resume_wait");
        chk("lim_count_clr", int'(cycle_count), 0);
        wait_state(S_HALT, 30, "lim_halt2_wait");
        chk("lim_runs2",  run_seen, 5);
        chk("lim_count2", int'(cycle_count), 5);
        chk("lim_flag2",  int'(limit_hit), 1);

        // Three single steps, the third at the breakpoint address
        do_reset();
        cycle_limit = '0; bp_enable = 1; bp_addr = 6'd2;
        m_pc = 0; current_pc = '0;
        for (int i = 0; i < 3; i++) begin
            int rs;
            rs = run_seen;
            press(0, 1, 0, 2);
            repeat (6) cyc();
            chk($sformatf("step%0d_pulses", i), run_seen - rs, 1);
            chk($sformatf("step%0d_state", i), int'(state), S_IDLE);
        end
        chk("step_count", int'(cycle_count), 3);
        chk("step_pc",    int'(current_pc), 3);

        // Simultaneous buttons: all three in HALT, then run+step in IDLE
        do_reset();
        bp_enable = 0; cycle_limit = 16'd2;
        press(1, 0, 0, 2);
        wait_state(S_HALT, 20, "sim_halt_wait");
        chk("sim_lh_set", int'(limit_hit), 1);
        press(1, 1, 1, 2);
        repeat (5) cyc();
        chk("sim_all_state", int'(state), S_IDLE);
        chk("sim_all_lh",    int'(limit_hit), 0);
        chk("sim_all_hab",   int'(halted_at_bp), 0);
        cycle_limit = '0;
        press(1, 1, 0, 1);
        begin
            int n;
            n = 0;
            while (int'(state) == S_IDLE && n < 10) begin
                cyc();
                n++;
            end
        end
        chk("sim_rs_state", int'(state), S_STEP);
        cyc();
        chk("sim_rs_back", int'(state), S_IDLE);

        // Clear during run, narrow-counter saturation, async reset mid-run
        do_reset();
        bp_enable = 0; cycle_limit = '0;
        press(1, 0, 0, 2);
        wait_state(S_RUN, 10, "clr_run_wait");
        repeat (3) cyc();
        clr_cnt = 1;
        cyc();
        clr_cnt = 0;
        chk("clr_zero", int'(cycle_count), 0);
        cyc();
        chk("clr_inc", int'(cycle_count), 1);
        repeat (20) cyc();
        chk("sat4_count", int'(cnt4), 15);
        chk("sat4_state", int'(state4), S_RUN);
        chk("sat4_run",   int'(run4), 1);
        begin
            int n;
            n = 0;
            while (cycle_count != 16'h1234 && n < 6000) begin
                cyc();
                n++;
            end
        end
        chk("pre_rst_count", int'(cycle_count), 'h1234);
        chk("pre_rst_run",   int'(run), 1);
        #2 reset = 1;
        #1;
        chk("arst_run",   int'(run), 0);
        chk("arst_state", int'(state), S_IDLE);
        chk("arst_count", int'(cycle_count), 0);
        chk("arst_cnt4",  int'(cnt4), 0);
        reset = 0;
        model_reset();

        // Randomized single-button traffic against the model
        for (int it = 0; it < 400; it++) begin
            int k;
            k = int'($urandom_range(0, 9));
            if (k < 3)       press(1, 0, 0, int'($urandom_range(1, 4)));
            else if (k < 5)  press(0, 1, 0, int'($urandom_range(1, 4)));
            else if (k == 5) press(0, 0, 1, int'($urandom_range(1, 4)));
            else if (k == 6) begin clr_cnt = 1; cyc(); clr_cnt = 0; end
            else if (k == 7) begin bp_enable = 1'($urandom); bp_addr = PC_W'($urandom); end
            else if (k == 8) cycle_limit = CNT_W'($urandom_range(0, 12));
            repeat ($urandom_range(0, 5)) cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
